greg_wb_arb: RTL and testbench

Write-port arbiter and pending-write scoreboard for the 2-read/1-write general register file. Shares the file's single write port among NREQ writeback requesters (ALU result, load data, multiply/divide unit) using a valid/ready handshake. Registers the winning write toward the file on the rising edge, so the file's falling-edge write sees stable inputs. Tracks registers with outstanding writes so decode can stall on read-after-write and write-after-write hazards.

---
 rtl/greg_wb_arb.sv | 123 ++++++++++++
 tb/tb_greg_wb_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/greg_wb_arb.sv
// Write-port arbiter and pending-write scoreboard for the 2R/1W general register file.
// Define GREG_WB_RR_EN for round-robin arbitration; fixed priority (port 0 first) otherwise.
module greg_wb_arb #(
    parameter int NREQ = 3
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [NREQ-1:0]     ReqVld,
    input  logic [5*NREQ-1:0]   ReqAddr,
    input  logic [32*NREQ-1:0]  ReqVal,
    output logic [NREQ-1:0]     ReqRdy,
    input  logic                RsvEn,
    input  logic [4:0]          RsvAddr,
    input  logic [4:0]          ChkAddr1,
    input  logic [4:0]          ChkAddr2,
    output logic                Hazard1,
    output logic                Hazard2,
    output logic [4:0]          WAddr,
    output logic [31:0]         WVal,
    output logic                WEn,
    output logic [31:0]         Busy
);

    logic [NREQ-1:0] grant;
    logic            xfer;
    logic [4:0]      win_addr;
    logic [31:0]     win_val;
    logic [31:0]     busy_q;
    logic [31:0]     busy_n;

`ifdef GREG_WB_RR_EN
    logic [1:0] last_q;
    logic [1:0] win_idx;

    // First valid port at or after (last+1), wrapping; last is always < NREQ.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] vld,
                                                input logic [1:0]      last);
        int start;
        int idx;
        rr_pick = '0;
        start   = int'(last) + 1;
        if (start >= NREQ) start = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = start + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (vld[idx] && rr_pick == '0) rr_pick[idx] = 1'b1;
        end
    endfunction

    assign grant = rr_pick(ReqVld, last_q);

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) win_idx = 2'(i);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            last_q <= 2'(NREQ - 1);
        end else if (xfer) begin
            last_q <= win_idx;
        end
    end
`else
    function automatic logic [NREQ-1:0] fp_pick(input logic [NREQ-1:0] vld);
        fp_pick = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (vld[i] && fp_pick == '0) fp_pick[i] = 1'b1;
        end
    endfunction

    assign grant = fp_pick(ReqVld);
`endif

    // Requesters must never see an accept while the block is held in reset.
    assign ReqRdy = grant & {NREQ{Rst}};
    assign xfer   = |grant;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        win_addr = '0;
        win_val  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_addr = ReqAddr[5*i +: 5];
                win_val  = ReqVal[32*i +: 32];
            end
        end
    end

    // Reservation is applied after the clear so a younger reservation survives.
    always_comb begin
        busy_n = busy_q;
        if (xfer) busy_n[win_addr] = 1'b0;
        if (RsvEn && RsvAddr != 5'd0) busy_n[RsvAddr] = 1'b1;
        busy_n[0] = 1'b0;
    end

    // NOTE: the scoreboard is reset like any control flop, since a reset drops all reservations.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            WEn    <= 1'b0;
            WAddr  <= '0;
            WVal   <= '0;
            busy_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so all flops sample together.
            WEn    <= xfer && (win_addr != 5'd0);
            busy_q <= busy_n;
            if (xfer) begin
                WAddr <= win_addr;
                WVal  <= win_val;
            end
        end
    end

    assign Busy    = busy_q;
    assign Hazard1 = busy_q[ChkAddr1];
    assign Hazard2 = busy_q[ChkAddr2];

endmodule

// File: tb/tb_greg_wb_arb.sv
// Scoreboard bench for greg_wb_arb: a queue-based reference model predicts each edge's
// write-register and scoreboard state; a monitor process pops and compares after every edge.
module tb_greg_wb_arb;

    localparam int NREQ = 3;

    logic                Clk;
    logic                Rst;
    logic [NREQ-1:0]     ReqVld;
    logic [5*NREQ-1:0]   ReqAddr;
    logic [32*NREQ-1:0]  ReqVal;
    logic [NREQ-1:0]     ReqRdy;
    logic                RsvEn;
    logic [4:0]          RsvAddr;
    logic [4:0]          ChkAddr1;
    logic [4:0]          ChkAddr2;
    logic                Hazard1;
    logic                Hazard2;
    logic [4:0]          WAddr;
    logic [31:0]         WVal;
    logic                WEn;
    logic [31:0]         Busy;

    greg_wb_arb #(.NREQ(NREQ)) dut (
        .Clk(Clk), .Rst(Rst),
        .ReqVld(ReqVld), .ReqAddr(ReqAddr), .ReqVal(ReqVal), .ReqRdy(ReqRdy),
        .RsvEn(RsvEn), .RsvAddr(RsvAddr),
        .ChkAddr1(ChkAddr1), .ChkAddr2(ChkAddr2),
        .Hazard1(Hazard1), .Hazard2(Hazard2),
        .WAddr(WAddr), .WVal(WVal), .WEn(WEn), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wval;
        logic [31:0] busy;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] mbusy;
    logic [4:0]  mwaddr;
    logic [31:0] mwval;
    int          mlast;

    // Values observed mid-cycle by the last step, for directed checks
    logic [NREQ-1:0] seen_rdy;
    logic            seen_h1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v);
`ifdef GREG_WB_RR_EN
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(mlast + k) % NREQ]) return (mlast + k) % NREQ;
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        mbusy  = '0;
        mwaddr = '0;
        mwval  = '0;
        mlast  = NREQ - 1;
    endtask

    // Drive one cycle at the falling edge, check combinational outputs, predict the edge.
    task automatic step(input logic [NREQ-1:0] vld, input logic [5*NREQ-1:0] a,
                        input logic [32*NREQ-1:0] d, input logic rsv_en,
                        input logic [4:0] rsv_addr, input logic [4:0] c1,
                        input logic [4:0] c2, output int win);
        logic [NREQ-1:0] erdy;
        logic            wen;
        exp_t            e;
        @(negedge Clk);
        ReqVld = vld; ReqAddr = a; ReqVal = d;
        RsvEn = rsv_en; RsvAddr = rsv_addr; ChkAddr1 = c1; ChkAddr2 = c2;
        #1;
        win  = pick(vld);
        erdy = '0;
        if (win >= 0) erdy[win] = 1'b1;
        seen_rdy = ReqRdy;
        seen_h1  = Hazard1;
        check("rdy", ReqRdy, erdy);
        check("haz1", Hazard1, (c1 != 0) && mbusy[c1]);
        check("haz2", Hazard2, (c2 != 0) && mbusy[c2]);
        wen = 1'b0;
        if (win >= 0) begin
            mwaddr = a[5*win +: 5];
            mwval  = d[32*win +: 32];
            mbusy[mwaddr] = 1'b0;
            mlast  = win;
            wen    = (mwaddr != 0);
        end
        if (rsv_en && rsv_addr != 0) mbusy[rsv_addr] = 1'b1;
        mbusy[0] = 1'b0;
        e.wen = wen; e.waddr = mwaddr; e.wval = mwval; e.busy = mbusy;
        q.push_back(e);
        @(posedge Clk);
        #2;
    endtask

    // Monitor: compare each edge's registered outputs against the oldest prediction.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("wen", WEn, e.wen);
            check("waddr", WAddr, e.waddr);
            check("wval", WVal, e.wval);
            check("busy", Busy, e.busy);
        end
    end

    initial begin
        int          w;
        logic [4:0]  cont_exp [3];
        logic [31:0] busy_before;
        logic            pv [NREQ];
        logic [4:0]      pa [NREQ];
        logic [31:0]     pd [NREQ];
        logic [NREQ-1:0]    v;
        logic [5*NREQ-1:0]  av;
        logic [32*NREQ-1:0] dv;

`ifdef GREG_WB_RR_EN
        cont_exp[0] = 5'd1; cont_exp[1] = 5'd2; cont_exp[2] = 5'd3;
`else
        cont_exp[0] = 5'd1; cont_exp[1] = 5'd1; cont_exp[2] = 5'd1;
`endif

        // Reset state, with a request present to prove ReqRdy is gated
        Rst = 1'b0; ReqVld = '1; ReqAddr = '0; ReqVal = '0;
        RsvEn = 1'b0; RsvAddr = '0; ChkAddr1 = '0; ChkAddr2 = '0;
        model_reset();
        #2;
        check("rst_wen", WEn, 1'b0);
        check("rst_waddr", WAddr, 5'd0);
        check("rst_wval", WVal, 32'd0);
        check("rst_busy", Busy, 32'd0);
        check("rst_rdy", ReqRdy, '0);
        @(negedge Clk);
        Rst = 1'b1; ReqVld = '0;

        // Contention: all ports valid with addresses 1,2,3 for three cycles
        for (int c = 0; c < 3; c++) begin
            step(3'b111, {5'd3, 5'd2, 5'd1}, {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001},
                 1'b0, 5'd0, 5'd0, 5'd0, w);
            check("cont_waddr", WAddr, cont_exp[c]);
        end

        // Single write: reserve 5, see the hazard, then port 1 writes it
        step(3'b000, '0, '0, 1'b1, 5'd5, 5'd5, 5'd0, w);
        check("rsv_no_bypass", seen_h1, 1'b0);
        step(3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEAD_BEEF, 32'd0},
             1'b0, 5'd0, 5'd5, 5'd0, w);
        check("single_haz1", seen_h1, 1'b1);
        check("single_rdy", seen_rdy, 3'b010);
        check("single_wen", WEn, 1'b1);
        check("single_waddr", WAddr, 5'd5);
        check("single_wval", WVal, 32'hDEAD_BEEF);
        check("single_busy5", Busy[5], 1'b0);

        // Idle gap (also reserves 9 so the scoreboard is non-empty)
        step(3'b000, '0, '0, 1'b1, 5'd9, 5'd0, 5'd0, w);
        check("idle_wen", WEn, 1'b0);
        check("idle_waddr", WAddr, 5'd5);
        check("idle_wval", WVal, 32'hDEAD_BEEF);

        // Zero address: accepted and consumed, no write, scoreboard untouched
        busy_before = mbusy;
        step(3'b001, {5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'h1234},
             1'b0, 5'd0, 5'd0, 5'd0, w);
        check("zero_rdy", seen_rdy, 3'b001);
        check("zero_wen", WEn, 1'b0);
        check("zero_busy", Busy, busy_before);

        // Set/clear collision on register 7
        step(3'b000, '0, '0, 1'b1, 5'd7, 5'd0, 5'd0, w);
        step(3'b001, {5'd0, 5'd0, 5'd7}, {32'd0, 32'd0, 32'h7777_7777},
             1'b1, 5'd7, 5'd0, 5'd0, w);
        check("coll_busy7", Busy[7], 1'b1);
        check("coll_wen", WEn, 1'b1);
        check("coll_waddr", WAddr, 5'd7);

        // Reset mid-transfer: outputs clear at once and stay cleared
        @(negedge Clk);
        ReqVld = 3'b001; ReqAddr = {5'd0, 5'd0, 5'd12}; ReqVal = {32'd0, 32'd0, 32'h55};
        #2;
        Rst = 1'b0;
        #1;
        check("mid_rst_wen", WEn, 1'b0);
        check("mid_rst_busy", Busy, 32'd0);
        check("mid_rst_rdy", ReqRdy, '0);
        @(posedge Clk);
        #1;
        check("mid_rst_hold_wen", WEn, 1'b0);
        check("mid_rst_hold_busy", Busy, 32'd0);
        check("mid_rst_hold_rdy", ReqRdy, '0);
        check("mid_rst_hold_waddr", WAddr, 5'd0);
        @(negedge Clk);
        Rst = 1'b1; ReqVld = '0;
        model_reset();

        // Randomized traffic: requesters hold until accepted, random reservations and checks
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    pv[i] = 1'b1;
                    pa[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    pd[i] = $urandom;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                v[i] = pv[i];
                av[5*i +: 5]   = pv[i] ? pa[i] : 5'($urandom);
                dv[32*i +: 32] = pv[i] ? pd[i] : 32'($urandom);
            end
            step(v, av, dv, $urandom_range(0, 2) == 0, 5'($urandom), 5'($urandom),
                 5'($urandom), w);
            if (w >= 0) pv[w] = 1'b0;
        end

        @(negedge Clk);
        ReqVld = '0; RsvEn = 1'b0;
        @(posedge Clk);
        #3;
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
